// File: rtl/pipe_ctrl.sv
// pipe_ctrl: sequencing controller for the 5-stage pipeline state tracker.
// Generates the tracker's stall/en inputs from run, halt and hazard requests.
// It also keeps saturating retire/stall statistics and a sticky
// illegal-stage-code flag.
//
// Ports
//   clk         in   system clock, rising edge
//   rst         in   asynchronous reset, active low
//   state_flat  in   tracker stage vector, stage k at [3k+2:3k], stage 4 oldest
//   run_req     in   pulse: start / resume advancing
//   halt_req    in   pulse: freeze the pipeline
//   hz_req      in   pulse: hazard stall request
//   hz_cycles   in   requested stall length (0 -> 1, clipped to STALL_MAX)
//   clr_cnt     in   synchronous clear of counters and err
//   stall       out  tracker stall input (registered)
//   en          out  tracker enable input (registered)
//   retire_cnt  out  saturating count of WB retirements
//   stall_cnt   out  saturating count of stall cycles
//   err         out  sticky illegal stage code flag
//   ctrl_state  out  FSM state: IDLE=0, RUN=1, STALL=2, HALT=3
module pipe_ctrl #(
   parameter int STALL_MAX = 3,
   parameter int CNT_W     = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [14:0]      state_flat,
   input  logic             run_req,
   input  logic             halt_req,
   input  logic             hz_req,
   input  logic [2:0]       hz_cycles,
   input  logic             clr_cnt,
   output logic             stall,
   output logic             en,
   output logic [CNT_W-1:0] retire_cnt,
   output logic [CNT_W-1:0] stall_cnt,
   output logic             err,
   output logic [1:0]       ctrl_state
);

   // Stage codes shared with the tracker (NOP, IF, ID, EX, MEM, WB).
   localparam logic [2:0] C_NOP = 3'd0;
   localparam logic [2:0] C_WB  = 3'd5;
   localparam logic [2:0] SMAX  = 3'(STALL_MAX);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      STALL = 2'd2,
      HALT  = 2'd3
   } state_t;

   state_t     state;
   logic [2:0] rem;
   logic       halt_pend;
   logic [2:0] eff_len;
   logic [2:0] rem_dec;
   logic [2:0] rem_ext;
   logic       bad_code;
   logic       retire_ev;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (&v) ? v : v + CNT_W'(1);
   endfunction

   // Codes are contiguous from NOP up to WB; anything above WB is illegal.
   function automatic logic code_legal(input logic [2:0] code);
      return (code >= C_NOP) && (code <= C_WB);
   endfunction

   always_comb begin
      if (hz_cycles == 3'd0)
         eff_len = 3'd1;
      else if (hz_cycles > SMAX)
         eff_len = SMAX;
      else
         eff_len = hz_cycles;
   end

   assign rem_dec = rem - 3'd1;
   // A new hazard during a stall may only lengthen it.
   assign rem_ext = (rem_dec > eff_len) ? rem_dec : eff_len;

   always_comb begin
      bad_code = 1'b0;
      for (int k = 0; k < 5; k++)
         if (!code_legal(state_flat[3*k +: 3]))
            bad_code = 1'b1;
   end

   assign retire_ev  = en && !stall && (state_flat[14:12] == C_WB);
   assign ctrl_state = state;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state     <= IDLE;
         en        <= 1'b0;
         stall     <= 1'b0;
         rem       <= 3'd0;
         halt_pend <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (run_req) begin
                  state <= RUN;
                  en    <= 1'b1;
                  stall <= 1'b0;
               end
            end
            RUN: begin
               if (halt_req) begin
                  state     <= HALT;
                  en        <= 1'b0;
                  stall     <= 1'b0;
                  halt_pend <= 1'b0;
               end else if (hz_req) begin
                  state <= STALL;
                  rem   <= eff_len;
                  en    <= 1'b1;
                  stall <= 1'b1;
               end
            end
            STALL: begin
               if (halt_req)
                  halt_pend <= 1'b1;
               if (hz_req) begin
                  rem <= rem_ext;
               end else if (rem <= 3'd1) begin
                  // Last stall cycle: leave to HALT if one is pending
                  // (including one arriving on this very edge).
                  rem <= 3'd0;
                  if (halt_pend || halt_req) begin
                     state     <= HALT;
                     en        <= 1'b0;
                     stall     <= 1'b0;
                     halt_pend <= 1'b0;
                  end else begin
                     state <= RUN;
                     en    <= 1'b1;
                     stall <= 1'b0;
                  end
               end else begin
                  rem <= rem_dec;
               end
            end
            HALT: begin
               if (run_req) begin
                  state <= RUN;
                  en    <= 1'b1;
                  stall <= 1'b0;
               end
            end
            default: begin
               state <= IDLE;
               en    <= 1'b0;
               stall <= 1'b0;
            end
         endcase
      end
   end

   // Statistics: clr_cnt takes precedence over any same-cycle event.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         retire_cnt <= '0;
         stall_cnt  <= '0;
         err        <= 1'b0;
      end else if (clr_cnt) begin
         retire_cnt <= '0;
         stall_cnt  <= '0;
         err        <= 1'b0;
      end else begin
         if (retire_ev)
            retire_cnt <= sat_inc(retire_cnt);
         if (stall)
            stall_cnt <= sat_inc(stall_cnt);
         if (bad_code)
            err <= 1'b1;
      end
   end

endmodule

// File: doc/pipe_ctrl.md
# pipe_ctrl

Pipeline sequencing controller: the driving side of the 5-stage pipeline state tracker. It observes the tracker's flattened stage vector, and from hazard, halt and run requests it generates the tracker's `stall` and `en` inputs. It also maintains retire and stall statistics and flags illegal stage codes. It sits between the hazard/debug logic and the `pipeline` tracker. Stage codes are the `defines.v` macros `NOP, `IF, `ID, `EX, `MEM, `WB.

## Interface
- STALL_MAX, 3: longest stall in cycles for a single request (1..7).
- CNT_W, 16: width of the statistics counters.

- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- state_flat  in  15  tracker stage vector. Stage k occupies bits [3k+2:3k]; stage 4 (bits 14:12) is the oldest.
- run_req  in  1  single-cycle pulse that starts or resumes advancing.
- halt_req  in  1  single-cycle pulse that freezes the pipeline.
- hz_req  in  1  single-cycle hazard pulse that requests a stall.
- hz_cycles  in  3  requested stall length. A value of 0 is treated as 1; values above STALL_MAX are clipped to STALL_MAX.
- clr_cnt  in  1  synchronous clear of the counters and of `err`.
- stall  out  1  drives the tracker's stall input. Registered.
- en  out  1  drives the tracker's en input. Registered.
- retire_cnt  out  CNT_W  number of WB-stage retirements. Saturating.
- stall_cnt  out  CNT_W  number of cycles with `stall`=1. Saturating.
- err  out  1  sticky flag: an illegal stage code was seen.
- ctrl_state  out  2  FSM state: IDLE=0, RUN=1, STALL=2, HALT=3.

## Operation
- **FSM state outputs:**
  - IDLE: en=0, stall=0.
  - RUN: en=1, stall=0.
  - STALL: en=1, stall=1.
  - HALT: en=0, stall=0.
- **Transitions:**
  - IDLE: run_req → RUN. hz_req and halt_req are ignored.
  - RUN, priority order halt_req > hz_req:
    - halt_req → HALT.
    - hz_req → STALL. Load `rem` with the effective length L (after the 0→1 and STALL_MAX rules).
  - STALL:
    - `rem` decrements by 1 each cycle. When `rem`=1, go to RUN, or to HALT if a halt is pending.
    - hz_req in STALL sets `rem` to max(rem−1, L). The stall is extended, never shortened.
    - halt_req in STALL sets `halt_pend`. The stall completes first, then the FSM enters HALT.
  - HALT: run_req → RUN. hz_req is ignored. `halt_pend` is cleared on entry to HALT.
  - run_req in RUN or STALL is ignored.
- **Retire counting:** on a cycle where en=1, stall=0 and state_flat[14:12]==`WB, increment retire_cnt (saturating).
- **Stall counting:** stall_cnt increments every cycle in which the `stall` output is 1 (saturating).
- **Illegal codes:** err is set on any cycle where any of the 5 fields of state_flat is not one of the six legal codes. It stays set until clr_cnt or reset.
- **clr_cnt:**
  - Zeroes retire_cnt, stall_cnt and err on the next edge. It does not affect the FSM.
  - If clr_cnt coincides with an increment or error event, the clear wins.
- **Counter widths:** counters hold at 2^CNT_W−1. `rem` is 3 bits wide.

## Timing
- **Reset:** state IDLE, stall=0, en=0, retire_cnt=0, stall_cnt=0, err=0, rem=0, halt_pend=0.
- **Mid-operation reset:** applying rst at any point forces the reset values immediately (asynchronously). The FSM does not recover any pending stall or halt.
- **Latency:** 1 cycle. A request sampled at edge n changes outputs after edge n.
- **Stall length:** an hz_req with effective length L yields exactly L consecutive cycles of stall=1, then en=1, stall=0. The stall is followed by HALT instead if a halt is pending.
- **Request timing:** requests are sampled only at clock edges, and a request lasting one cycle is sufficient. A held request is re-evaluated every cycle; in STALL a held hz_req keeps extending the stall.
- **Counter observation:** retire and stall counters are updated on the edge that ends the qualifying cycle, so they are visible one cycle later.

## Test plan
- **Reset and run:** release reset, pulse run_req at cycle 2 → en=1 from cycle 3 and ctrl_state=1. Feed state_flat with field 4=`WB for 4 advancing cycles → retire_cnt=4.
- **Basic stall:** in RUN, hz_req with hz_cycles=2 → stall=1 for exactly 2 cycles, stall_cnt=2, back to RUN. With hz_cycles=0 → 1 cycle. With hz_cycles=7 and STALL_MAX=3 → 3 cycles.
- **Stall extension and halt:**
  - hz_req(3), then hz_req(3) one cycle later → stall lasts 4 cycles total.
  - halt_req during the stall → HALT entered right after the last stall cycle, en=0.
- **Halt priority:** halt_req and hz_req in the same RUN cycle → HALT, with no stall cycle. In HALT, hz_req has no effect; run_req → RUN.
- **Illegal code and clear:** drive field 2 with an illegal code (a value not among the six `defines.v` stage codes) for 1 cycle → err=1 and stays set. Pulse clr_cnt → err=0 and counters=0, FSM state unchanged.
- **Saturation and reset:** with CNT_W=4, hold stall through 20 stall cycles → stall_cnt holds at 15. Assert rst mid-STALL → all outputs return to their reset values immediately.
